// File: rtl/iagc_ctrl_fsm.sv
`default_nettype none
// iagc_ctrl_fsm -- IAGC top control FSM: N-channel round-robin sampling, valid/ready commands,
// error reporting; optional watchdog when IAGC_CTRL_TIMEOUT_EN is defined.  Rev 1.0
module iagc_ctrl_fsm #(
  parameter int N_CH           = 4,
  parameter int CH_W           = 2,
  parameter int CMD_W          = 3,
  parameter int ERR_CNT_W      = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_init_done,
  input  logic [N_CH-1:0]      i_sample_req,
  input  logic                 i_cmd_valid,
  input  logic [CMD_W-1:0]     i_cmd_opcode,
  input  logic [CH_W-1:0]      i_cmd_arg,
  output logic                 o_cmd_ready,
  input  logic                 i_sample_end,
  input  logic                 i_dump_end,
  input  logic                 i_clean_end,
  output logic                 o_sample_start,
  output logic                 o_dump_start,
  output logic                 o_clean_start,
  output logic [CH_W-1:0]      o_channel,
  output logic                 o_soft_reset,
  output logic [3:0]           o_status,
  output logic [1:0]           o_err_code,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  localparam logic [3:0] S_RESET   = 4'd0;
  localparam logic [3:0] S_INIT    = 4'd1;
  localparam logic [3:0] S_IDLE    = 4'd2;
  localparam logic [3:0] S_SAMPLE  = 4'd3;
  localparam logic [3:0] S_DECODE  = 4'd4;
  localparam logic [3:0] S_ERROR   = 4'd6;
  localparam logic [3:0] S_DUMP    = 4'd7;
  localparam logic [3:0] S_CLEAN   = 4'd8;
  localparam logic [3:0] S_TIMEOUT = 4'd9;

  localparam logic [CMD_W-1:0] OP_RESET  = CMD_W'(1);
  localparam logic [CMD_W-1:0] OP_SAMPLE = CMD_W'(2);
  localparam logic [CMD_W-1:0] OP_DUMP   = CMD_W'(3);
  localparam logic [CMD_W-1:0] OP_CLEAN  = CMD_W'(4);

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_TMO    = 2'b10;
  localparam logic [1:0] ERR_CHAN   = 2'b11;

  localparam int SUM_W = CH_W + 1;
  localparam int REQ_W = 1 << CH_W;
  localparam logic [SUM_W-1:0] NCH_V = SUM_W'(N_CH);
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]       state, state_nxt;
  logic [CMD_W-1:0] op_q;
  logic [CH_W-1:0]  arg_q;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  grant_ch;
  logic             grant_vld;
  logic [SUM_W-1:0] sum;
  logic [REQ_W-1:0] req_ext;
  logic             err_set;
  logic [1:0]       err_nxt;
  logic             tmo_hit;

  assign o_status     = state;
  assign o_soft_reset = (state == S_RESET);
  assign o_cmd_ready  = (state == S_IDLE);

  // Round-robin: first requester strictly after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    req_ext   = REQ_W'(i_sample_req);
    grant_vld = 1'b0;
    grant_ch  = '0;
    sum       = '0;
    for (int i = 1; i <= N_CH; i++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (sum >= NCH_V) sum = sum - NCH_V;
      if (!grant_vld && req_ext[sum[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = sum[CH_W-1:0];
      end
    end
  end

`ifdef IAGC_CTRL_TIMEOUT_EN
  logic [TMR_W-1:0] tmr;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      tmr <= '0;
    end else if (state == S_SAMPLE || state == S_DUMP || state == S_CLEAN) begin
      tmr <= tmr + TMR_W'(1);
    end else begin
      tmr <= '0;
    end
  end

  assign tmo_hit = (tmr == TMR_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = ^TMR_LAST;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_nxt   = o_err_code;
    case (state)
      S_RESET: state_nxt = S_INIT;
      S_INIT:  if (i_init_done) state_nxt = S_IDLE;
      S_IDLE: begin
        if (i_cmd_valid)    state_nxt = S_DECODE;
        else if (grant_vld) state_nxt = S_SAMPLE;
      end
      S_DECODE: begin
        case (op_q)
          OP_RESET: state_nxt = S_RESET;
          OP_SAMPLE: begin
            if ({1'b0, arg_q} < NCH_V) begin
              state_nxt = S_SAMPLE;
            end else begin
              state_nxt = S_ERROR;
              err_set   = 1'b1;
              err_nxt   = ERR_CHAN;
            end
          end
          OP_DUMP:  state_nxt = S_DUMP;
          OP_CLEAN: state_nxt = S_CLEAN;
          default: begin
            state_nxt = S_ERROR;
            err_set   = 1'b1;
            err_nxt   = ERR_OPCODE;
          end
        endcase
      end
      S_SAMPLE, S_DUMP, S_CLEAN: begin
        // The matching end input takes precedence over an expiring watchdog.
        if ((state == S_SAMPLE && i_sample_end) ||
            (state == S_DUMP   && i_dump_end)   ||
            (state == S_CLEAN  && i_clean_end)) begin
          state_nxt = S_IDLE;
        end else if (tmo_hit) begin
          state_nxt = S_TIMEOUT;
          err_set   = 1'b1;
          err_nxt   = ERR_TMO;
        end
      end
      S_ERROR, S_TIMEOUT: state_nxt = S_IDLE;
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Entering RESET from a command clears the same context as the hardware reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n || state_nxt == S_RESET) begin
      rr_ptr         <= CH_W'(N_CH - 1);
      o_channel      <= '0;
      o_err_code     <= ERR_NONE;
      o_err_count    <= '0;
      o_sample_start <= 1'b0;
      o_dump_start   <= 1'b0;
      o_clean_start  <= 1'b0;
      op_q           <= '0;
      arg_q          <= '0;
    end else begin
      o_sample_start <= (state_nxt == S_SAMPLE) && (state != S_SAMPLE);
      o_dump_start   <= (state_nxt == S_DUMP)   && (state != S_DUMP);
      o_clean_start  <= (state_nxt == S_CLEAN)  && (state != S_CLEAN);
      if (state == S_IDLE && i_cmd_valid) begin
        op_q  <= i_cmd_opcode;
        arg_q <= i_cmd_arg;
      end
      if (state == S_IDLE && !i_cmd_valid && grant_vld) begin
        o_channel <= grant_ch;
        rr_ptr    <= grant_ch;
      end
      if (state == S_DECODE && state_nxt == S_SAMPLE) begin
        o_channel <= arg_q;
      end
      if (err_set) begin
        o_err_code <= err_nxt;
        if (o_err_count != '1) o_err_count <= o_err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/iagc_ctrl_fsm.md
# iagc_ctrl_fsm

Parametrised top-level control state machine for the IAGC datapath: it generalises the single-source controller to N sample channels with round-robin arbitration, a valid/ready command port with opcode and channel argument, sub-block start pulses, error reporting with a saturating error counter, and an optional watchdog. It sits between the command/UART decoder and the ADC sampler, memory dumper and memory cleaner, and is the sole owner of the system status word.

## Interface
- `N_CH`, 4, number of sample channels (2..16).
- `CH_W`, 2, width of channel index; must hold N_CH-1.
- `CMD_W`, 3, opcode width.
- `ERR_CNT_W`, 8, width of error counter.
- `TIMEOUT_CYCLES`, 65536, watchdog limit per operation (≥2).
- `i_clock` in 1: single clock, rising edge.
- `i_reset_n` in 1: synchronous, active-low reset.
- `i_init_done` in 1: ADC initialisation complete.
- `i_sample_req` in N_CH: per-channel sample request (level).
- `i_cmd_valid` in 1: command present.
- `i_cmd_opcode` in CMD_W: 1 = reset, 2 = sample, 3 = dump, 4 = clean; others illegal.
- `i_cmd_arg` in CH_W: channel for sample opcode.
- `o_cmd_ready` out 1: command accepted when valid && ready.
- `i_sample_end`, `i_dump_end`, `i_clean_end` in 1: sub-block done.
- `o_sample_start`, `o_dump_start`, `o_clean_start` out 1: single-cycle start pulses.
- `o_channel` out CH_W: channel of current/last sample.
- `o_soft_reset` out 1: high while status = RESET.
- `o_status` out 4: current state encoding.
- `o_err_code` out 2: 00 none, 01 bad opcode, 10 timeout, 11 bad channel.
- `o_err_count` out ERR_CNT_W: saturating error count.

## Operation
- States and encodings: RESET 0, INIT 1, IDLE 2, SAMPLE 3, CMD_DECODE 4, CMD_ERROR 6, DUMP 7, CLEAN 8, TIMEOUT 9. Unused codes go to RESET.
- RESET → INIT unconditionally. INIT → IDLE when `i_init_done`.
- IDLE: `o_cmd_ready` = 1 (only in IDLE). Command handshake has priority: latch opcode/arg, go to CMD_DECODE. Else, if any `i_sample_req` bit is set, grant the first requesting channel strictly after the RR pointer (wrapping), load `o_channel`, update pointer to the granted channel, go to SAMPLE.
- CMD_DECODE: reset → RESET; sample with arg < N_CH → SAMPLE, `o_channel` = arg, RR pointer unchanged; sample with arg ≥ N_CH → CMD_ERROR (code 11); dump → DUMP; clean → CLEAN; other → CMD_ERROR (code 01).
- SAMPLE/DUMP/CLEAN: the start pulse is high for the first cycle in the state only; exit to IDLE on the matching end input, which is sampled every cycle in the state including the first. End inputs outside their state are ignored.
- CMD_ERROR, TIMEOUT: one cycle, then IDLE.
- Errors: on entry to CMD_ERROR/TIMEOUT, set `o_err_code` and increment `o_err_count`, saturating at all-ones. The code holds until the next error or reset; a successful op does not clear it.
- Command reset (opcode 1) behaves as hardware reset: clears err code/count and the RR pointer.

## Timing
- Reset (`i_reset_n` = 0 at edge): status 0, all pulses 0, `o_channel` 0, err code/count 0, RR pointer N_CH-1 (channel 0 wins first), `o_cmd_ready` 0, `o_soft_reset` 1.
- All outputs are registered or decoded from the state register only; no combinational input-to-output path except none.
- Command latency: handshake at edge N; CMD_DECODE during N..N+1; action state and start pulse in the cycle after edge N+1.
- Sample arbitration latency: request seen in IDLE at edge N → SAMPLE, `o_sample_start` = 1, `o_channel` valid in the cycle after edge N.
- A reset asserted mid-operation aborts immediately; no end input is awaited.

## Configuration
- `IAGC_CTRL_TIMEOUT_EN` defined: a counter clears on entry to SAMPLE/DUMP/CLEAN and counts each cycle. If the count reaches TIMEOUT_CYCLES-1 without the end input, go to TIMEOUT (code 10). If end and timeout occur in the same cycle, end wins.
- Undefined: no counter; ops wait indefinitely; TIMEOUT unreachable; code 10 never produced.

## Test plan
- Reset release with `i_init_done` = 1 two cycles later → status 0,1,1,2; `o_cmd_ready` rises with status 2.
- `i_sample_req` = 4'b1111 held, end returned each entry cycle → `o_channel` sequence 0,1,2,3,0; one `o_sample_start` per grant.
- Command valid with request pending in IDLE, opcode 2, arg 3 → CMD_DECODE then SAMPLE, `o_channel` = 3; RR order afterwards unchanged.
- Opcode 7, then opcode 2 with arg 5 on N_CH = 4 (CH_W = 3) → err code 01 then 11, `o_err_count` = 2. Then 300 more errors with ERR_CNT_W = 8 → count 255.
- With timeout enabled and TIMEOUT_CYCLES = 16, DUMP with no end → TIMEOUT after 16 cycles in DUMP, code 10. Repeat with end at cycle 16 → IDLE, no error.
- Opcode 1 mid-DUMP path and `i_reset_n` low during CLEAN → status 0, `o_soft_reset` 1, err count 0.
